// File: rtl/lcd_driver.sv
// RGB-interface LCD timing generator: panel timing chosen by lcd_id at reset,
// pixel coordinates requested one cycle ahead of the registered panel outputs.
module lcd_driver (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [15:0] lcd_id,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_row,
    output logic [10:0] pixel_line,
    output logic        lcd_clk,
    output logic [23:0] lcd_rgb,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de
);

    typedef enum logic [2:0] {
        T_4342 = 3'd0,
        T_7084 = 3'd1,
        T_7016 = 3'd2,
        T_4384 = 3'd3,
        T_1018 = 3'd4
    } timing_t;

    timing_t     sel;
    logic [10:0] h_cnt, v_cnt;
    logic [10:0] h_sync, h_back, h_disp, h_total;
    logic [10:0] v_sync, v_back, v_disp, v_total;
    logic [10:0] h_start, h_end, v_start, v_end;
    logic        req;

    assign lcd_clk = pclk;

    // Timing select only follows lcd_id while held in reset.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            case (lcd_id)
                16'h7084: sel <= T_7084;
                16'h7016: sel <= T_7016;
                16'h4384: sel <= T_4384;
                16'h1018: sel <= T_1018;
                default:  sel <= T_4342;
            endcase
        end
    end

    always_comb begin
        h_sync  = 11'd41;  h_back = 11'd2;  h_disp = 11'd480;  h_total = 11'd525;
        v_sync  = 11'd10;  v_back = 11'd2;  v_disp = 11'd272;  v_total = 11'd286;
        case (sel)
            T_7084, T_4384: begin
                h_sync = 11'd128; h_back = 11'd88;  h_disp = 11'd800;  h_total = 11'd1056;
                v_sync = 11'd2;   v_back = 11'd33;  v_disp = 11'd480;  v_total = 11'd525;
            end
            T_7016: begin
                h_sync = 11'd20;  h_back = 11'd140; h_disp = 11'd1024; h_total = 11'd1344;
                v_sync = 11'd3;   v_back = 11'd20;  v_disp = 11'd600;  v_total = 11'd635;
            end
            T_1018: begin
                h_sync = 11'd10;  h_back = 11'd80;  h_disp = 11'd1280; h_total = 11'd1440;
                v_sync = 11'd3;   v_back = 11'd10;  v_disp = 11'd800;  v_total = 11'd823;
            end
            default: ;
        endcase
    end

    // Horizontal window opens one count early so the request leads the registered outputs.
    assign h_start = h_sync + h_back - 11'd1;
    assign h_end   = h_start + h_disp;
    assign v_start = v_sync + v_back;
    assign v_end   = v_start + v_disp;

    assign req = (h_cnt >= h_start) && (h_cnt < h_end) &&
                 (v_cnt >= v_start) && (v_cnt < v_end);

    assign pixel_row  = req ? (h_cnt - h_start) : 11'd0;
    assign pixel_line = req ? (v_cnt - v_start) : 11'd0;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            h_cnt <= 11'd0;
            v_cnt <= 11'd0;
        end else if (h_cnt == h_total - 11'd1) begin
            h_cnt <= 11'd0;
            v_cnt <= (v_cnt == v_total - 11'd1) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            lcd_de  <= 1'b0;
            lcd_rgb <= 24'h0;
            lcd_hs  <= 1'b1;
            lcd_vs  <= 1'b1;
        end else begin
            lcd_de  <= req;
            lcd_rgb <= req ? pixel_data : 24'h0;
            lcd_hs  <= ~(h_cnt < h_sync);
            lcd_vs  <= ~(v_cnt < v_sync);
        end
    end

endmodule

// File: tb/tb_lcd_driver.sv
// Bench for lcd_driver: per-panel timing table, cycle scoreboard of the panel outputs,
// pixel ramp checks and a mid-line reset.
module tb_lcd_driver;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic [15:0] lcd_id;
    logic [23:0] pixel_data;
    logic [10:0] pixel_row, pixel_line;
    logic        lcd_clk, lcd_hs, lcd_vs, lcd_de;
    logic [23:0] lcd_rgb;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    // Source returns its own coordinate so both row and line are visible on lcd_rgb.
    assign pixel_data = {2'b00, pixel_line, pixel_row};

    lcd_driver dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .lcd_id     (lcd_id),
        .pixel_data (pixel_data),
        .pixel_row  (pixel_row),
        .pixel_line (pixel_line),
        .lcd_clk    (lcd_clk),
        .lcd_rgb    (lcd_rgb),
        .lcd_hs     (lcd_hs),
        .lcd_vs     (lcd_vs),
        .lcd_de     (lcd_de)
    );

    typedef struct {
        logic [15:0] id;
        int hs, hb, hd, vs, vb, vd, ht, vt;
        int lines;
        bit ramp;
    } cfg_t;

    typedef struct {
        logic        de;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    cfg_t cfgs[4];
    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_cfg(input int idx, input int nlines, input bit do_reset);
        cfg_t c;
        exp_t e, n;
        int ncyc, mh, mv, er, el, ramp0, dl, vs_exp;
        int n_de, n_rgb, n_hs, n_vs, n_co, hs_low, vs_low, de_cnt, de_rises, first_rise;
        logic prev_de;
        bit req;
        c = cfgs[idx];
        ncyc = nlines * c.ht;
        mh = 0; mv = 0;
        n_de = 0; n_rgb = 0; n_hs = 0; n_vs = 0; n_co = 0;
        hs_low = 0; vs_low = 0; de_cnt = 0; de_rises = 0; first_rise = -1;
        prev_de = 1'b0;
        ramp0 = (c.vs + c.vb) * c.ht + c.hs + c.hb - 1;
        if (do_reset) begin
            @(negedge pclk);
            rst_n  = 1'b0;
            lcd_id = c.id;
            repeat (3) @(negedge pclk);
            rst_n  = 1'b1;
        end
        lcd_id = ~c.id;  // must be ignored until the next reset
        sb.delete();
        e = '{de: 1'b0, rgb: 24'h0, hs: 1'b1, vs: 1'b1};
        sb.push_back(e);
        for (int i = 0; i < ncyc; i++) begin
            e = sb.pop_front();
            if (lcd_de  !== e.de)  n_de++;
            if (lcd_rgb !== e.rgb) n_rgb++;
            if (lcd_hs  !== e.hs)  n_hs++;
            if (lcd_vs  !== e.vs)  n_vs++;
            if (!lcd_hs) hs_low++;
            if (!lcd_vs) vs_low++;
            if (lcd_de) de_cnt++;
            if (lcd_de && !prev_de) begin
                de_rises++;
                if (first_rise < 0) first_rise = i;
            end
            prev_de = lcd_de;

            req = (mh >= c.hs + c.hb - 1) && (mh < c.hs + c.hb + c.hd - 1) &&
                  (mv >= c.vs + c.vb) && (mv < c.vs + c.vb + c.vd);
            er = req ? mh - (c.hs + c.hb - 1) : 0;
            el = req ? mv - (c.vs + c.vb) : 0;
            if (int'(pixel_row) !== er || int'(pixel_line) !== el) n_co++;

            if (c.ramp) begin
                if (i == ramp0) begin
                    check("ramp_row0", int'(pixel_row), 0);
                    check("ramp_line0", int'(pixel_line), 0);
                end
                if (i == ramp0 + 1) begin
                    check("ramp_first_de", int'(lcd_de), 1);
                    check("ramp_first_rgb", int'(lcd_rgb), 0);
                end
                if (i == ramp0 + c.hd) check("ramp_last_rgb", int'(lcd_rgb), c.hd - 1);
                if (i == ramp0 + c.hd + 1) begin
                    check("ramp_end_de", int'(lcd_de), 0);
                    check("ramp_end_rgb", int'(lcd_rgb), 0);
                end
            end

            n.de  = req;
            n.rgb = req ? {2'b00, el[10:0], er[10:0]} : 24'h0;
            n.hs  = !(mh < c.hs);
            n.vs  = !(mv < c.vs);
            sb.push_back(n);
            mh++;
            if (mh == c.ht) begin
                mh = 0;
                mv = (mv == c.vt - 1) ? 0 : mv + 1;
            end
            @(negedge pclk);
        end

        check("seq_de", n_de, 0);
        check("seq_rgb", n_rgb, 0);
        check("seq_hs", n_hs, 0);
        check("seq_vs", n_vs, 0);
        check("seq_coord", n_co, 0);
        dl = (nlines > c.vs + c.vb) ? nlines - (c.vs + c.vb) : 0;
        if (dl > c.vd) dl = c.vd;
        vs_exp = (nlines <= c.vs) ? nlines * c.ht - 1 : c.vs * c.ht;
        check("hs_low_cycles", hs_low, nlines * c.hs);
        check("vs_low_cycles", vs_low, vs_exp);
        check("de_lines", de_rises, dl);
        check("de_cycles", de_cnt, dl * c.hd);
        if (dl > 0) check("first_de_cycle", first_rise, ramp0 + 1);
    endtask

    initial begin
        cfgs[0] = '{16'h4342, 41, 2, 480, 10, 2, 272, 525, 286, 14, 1'b1};
        cfgs[1] = '{16'h7084, 128, 88, 800, 2, 33, 480, 1056, 525, 36, 1'b0};
        cfgs[2] = '{16'h1234, 41, 2, 480, 10, 2, 272, 525, 286, 14, 1'b1};
        cfgs[3] = '{16'h1018, 10, 80, 1280, 3, 10, 800, 1440, 823, 14, 1'b1};

        rst_n  = 1'b0;
        lcd_id = 16'h4342;
        repeat (2) @(posedge pclk);
        #1;
        check("lcd_clk_high_in_rst", int'(lcd_clk), 1);
        @(negedge pclk);
        check("lcd_clk_low_in_rst", int'(lcd_clk), 0);
        check("rst_de", int'(lcd_de), 0);
        check("rst_rgb", int'(lcd_rgb), 0);
        check("rst_hs", int'(lcd_hs), 1);
        check("rst_vs", int'(lcd_vs), 1);

        for (int k = 0; k < 4; k++) run_cfg(k, cfgs[k].lines, 1'b1);

        // Reset in the middle of an active line, then confirm a clean restart.
        @(negedge pclk);
        rst_n  = 1'b0;
        lcd_id = 16'h4342;
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        repeat (12 * 525 + 100) @(negedge pclk);
        check("pre_rst_de", int'(lcd_de), 1);
        rst_n = 1'b0;
        @(negedge pclk);
        check("mid_rst_de", int'(lcd_de), 0);
        check("mid_rst_rgb", int'(lcd_rgb), 0);
        check("mid_rst_hs", int'(lcd_hs), 1);
        check("mid_rst_vs", int'(lcd_vs), 1);
        check("mid_rst_row", int'(pixel_row), 0);
        check("mid_rst_line", int'(pixel_line), 0);
        rst_n = 1'b1;
        run_cfg(0, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_driver.md
Name: lcd_driver

Overview:
- RGB-interface LCD timing generator for parallel TFT panels.
- Produces the HS/VS/DE/pixel-clock/RGB signals, with the timing set selected by the panel ID `lcd_id`.
- Issues pixel coordinate requests (`pixel_row`, `pixel_line`) one cycle ahead to an upstream pixel source, which returns `pixel_data` combinationally in the same cycle.
- Sits between the frame-buffer/pattern source and the panel pins.

Parameters:
- None. All timing comes from internal tables selected by `lcd_id`.

Ports:
- pclk  input  1  pixel clock; all logic is on its rising edge
- rst_n  input  1  synchronous active-low reset
- lcd_id  input  16  panel ID; sampled while rst_n=0
- pixel_data  input  24  RGB888 for the requested coordinate, valid in the same cycle
- pixel_row  output  11  requested horizontal pixel index x (0..H_DISP-1); 0 when no request
- pixel_line  output  11  requested vertical line index y (0..V_DISP-1); 0 when no request
- lcd_clk  output  1  panel pixel clock, equal to pclk (direct pass-through)
- lcd_rgb  output  24  panel RGB data
- lcd_hs  output  1  horizontal sync, active low
- lcd_vs  output  1  vertical sync, active low
- lcd_de  output  1  data enable, active high

Behaviour:
- Timing tables. Values are H sync/back/disp/front, total; then V sync/back/disp/front, total.
  - ID 0x4342: H 41/2/480/2, total 525; V 10/2/272/2, total 286.
  - ID 0x7084: H 128/88/800/40, total 1056; V 2/33/480/10, total 525.
  - ID 0x7016: H 20/140/1024/160, total 1344; V 3/20/600/12, total 635.
  - ID 0x4384: H 128/88/800/40, total 1056; V 2/33/480/10, total 525.
  - ID 0x1018: H 10/80/1280/70, total 1440; V 3/10/800/10, total 823.
  - Any other ID uses the 0x4342 timing.
- ID latching:
  - A registered timing select is loaded from `lcd_id` on every clock edge while rst_n=0.
  - It is held constant while rst_n=1. Changing `lcd_id` mid-frame has no effect until the next reset.
- Counters:
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, then wraps to 0.
  - Reset sets both to 0.
  - Counter width is 11 bits.
- Request window (combinational from the counters):
  - req = (HS+HB-1 <= h_cnt < HS+HB+HD-1) AND (VS+VB <= v_cnt < VS+VB+VD).
  - When req: pixel_row = h_cnt-(HS+HB-1) and pixel_line = v_cnt-(VS+VB).
  - When not req: both are 0.
- Registered outputs, updated each pclk edge:
  - lcd_de <= req.
  - lcd_rgb <= req ? pixel_data : 24'h0.
  - lcd_hs <= ~(h_cnt < HS).
  - lcd_vs <= ~(v_cnt < VS).
- Latency: the pixel requested at coordinate (x,y) appears on lcd_rgb one cycle later, together with lcd_de=1.
- Alignment: lcd_de is high for exactly HD consecutive cycles per active line and for VD lines per frame. lcd_de, lcd_hs and lcd_vs share the same one-cycle register delay relative to the counters.
- Reset values: lcd_de=0, lcd_rgb=0, lcd_hs=1, lcd_vs=1, counters 0. Consequently pixel_row=0 and pixel_line=0.
- Reset asserted mid-frame: on the next edge all outputs take their reset values and the counters restart from 0.
- lcd_clk follows pclk at all times, including during reset.
- Frame period = H_TOTAL*V_TOTAL pclk cycles.

Test Plan:
- ID 0x4342, release reset:
  - lcd_hs low for 41 cycles of every 525.
  - lcd_vs low for 10 lines (5250 cycles) of every 150150 cycles.
- ID 0x4342, pixel_data={13'd0,pixel_row}:
  - At v_cnt=12, h_cnt=42: pixel_row=0 and pixel_line=0.
  - Next cycle: lcd_de=1 and lcd_rgb=0.
  - lcd_rgb then ramps 1,2,...,479 over 480 cycles; lcd_de=0 afterwards with lcd_rgb=0.
- ID 0x4342, per frame: lcd_de high for 272 lines; pixel_line spans 0..271; outside the window pixel_row and pixel_line are 0.
- ID 0x7084, with a reset between ID changes: H_TOTAL=1056, 800 DE cycles per line, 480 DE lines, HS low for 128 cycles, VS low for 2 lines.
- Unknown ID 0x1234: timing identical to 0x4342.
- rst_n driven low mid-line while lcd_de=1:
  - Next edge: lcd_de=0, lcd_rgb=0, lcd_hs=1, lcd_vs=1.
  - After release, the frame restarts from counter 0.
